shared_mem_arbiter: RTL
=======================

# shared_mem_arbiter

Round-robin arbiter between the processor cores and the single-port shared data `RAM`. It sits directly upstream of the RAM and drives its `wrEn`/`addr`/`dataIn`. Each core issues a request and holds it until acknowledged. The arbiter serialises requests, performs one RAM access per grant, and returns read data with a one-cycle `core_ready` pulse.

## Interface
Parameters:
- `CORE_COUNT`, 4: number of requesting cores (≥2).
- `WIDTH`, 12: data word width; equals RAM `WIDTH`.
- `DEPTH`, 4096: RAM words; equals RAM `DEPTH`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `core_req` in `[CORE_COUNT-1:0]`: per-core request level.
- `core_wrEn` in `[CORE_COUNT-1:0]`: 1 = write, 0 = read; qualified by `core_req`.
- `core_addr` in `[CORE_COUNT-1:0][ADDR_WIDTH-1:0]`: per-core address.
- `core_dataIn` in `[CORE_COUNT-1:0][WIDTH-1:0]`: per-core write data.
- `core_ready` out `[CORE_COUNT-1:0]`: one-hot, one-cycle completion pulse.
- `core_dataOut` out `WIDTH`: read data broadcast; valid for the core whose `core_ready` bit is high.
- `ram_wrEn` out 1: to RAM `wrEn`.
- `ram_addr` out `ADDR_WIDTH`: to RAM `addr`.
- `ram_dataIn` out `WIDTH`: to RAM `dataIn`.
- `ram_dataOut` in `WIDTH`: from RAM `dataOut`, valid the cycle after RAM samples `addr`.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESPOND`.
- `IDLE`:
  - If no bit of `core_req` is set, stay in `IDLE`.
  - Otherwise, select the winner as the first set bit searching upward from `rr_ptr`, wrapping modulo `CORE_COUNT`.
  - On the edge, latch the winner's index, `core_wrEn`, `core_addr` and `core_dataIn` into registers; go to `ACCESS`.
- `ACCESS`:
  - `ram_wrEn`/`ram_addr`/`ram_dataIn` are driven from the latched registers.
  - The RAM performs the write, or samples the read address, on the exiting edge. Go to `RESPOND`.
- `RESPOND`:
  - `core_ready[winner]` = 1; `core_dataOut` = `ram_dataOut`. For writes the value is don't-care but still driven.
  - `ram_wrEn` = 0.
  - On the edge: `rr_ptr` ← (winner+1) mod `CORE_COUNT`; go to `IDLE`.
- `ram_wrEn` is high only in `ACCESS` with a latched write. In all other states it is 0.
- Core protocol:
  - A core holds `core_req`, `core_wrEn`, `core_addr` and `core_dataIn` stable until it samples `core_ready` high.
  - It deasserts `core_req` at that same edge unless it issues a new request.
  - Changes to non-granted cores' inputs have no effect. Once latched, the granted core's inputs are ignored.
- Fairness: a continuously requesting core is granted within `CORE_COUNT` grants.
- `core_ready` is never multi-hot. It is never high outside `RESPOND`.

## Timing
- Reset values:
  - state = `IDLE`, `rr_ptr` = 0, latched registers = 0.
  - `ram_wrEn` = 0, `ram_addr` = 0, `ram_dataIn` = 0.
  - `core_ready` = 0, `core_dataOut` = 0.
- Latency: request sampled at edge E0 (in `IDLE`) → RAM access at edge E1 → `core_ready` high in the cycle after E1, sampled by the core at E2.
- Throughput: one access per 3 cycles.
- Back-to-back: a request present in `IDLE` right after `RESPOND` is granted with no extra idle cycle.
- Simultaneous requests in `IDLE`: exactly one winner, chosen by `rr_ptr` order. The others wait with requests held.
- Reset asserted mid-operation:
  - Outputs go immediately (asynchronously) to their reset values.
  - A pending `ACCESS` write whose edge has not occurred is not performed.
  - No `core_ready` is issued for the aborted access. The core re-requests after reset.
- `rr_ptr` wrap: winner `CORE_COUNT-1` → `rr_ptr` = 0.

## Test plan
- Single write then read: core 0 writes 100 to addr 3, then reads addr 3 → `ram_wrEn` high for exactly 1 cycle; `core_ready[0]` pulses 2 cycles after each request edge; read `core_dataOut` = 100.
- Simultaneous requests: cores 0–3 request reads of addr 0–3 (preloaded 10, 20, 30, 40) at the same edge from reset → grant order 0, 1, 2, 3 at 3-cycle spacing; each `core_dataOut` matches its own word; `core_ready` always one-hot.
- Round-robin fairness: core 0 requests continuously while cores 1 and 3 request once → order 0, 1, 3, 0; `rr_ptr` wraps 3 → 0.
- Write contention on same address: core 1 writes 55 and core 2 writes 77 to addr 5, both at the same edge with `rr_ptr` = 1 → final RAM[5] = 77; a subsequent read returns 77.
- Reset in `ACCESS`: assert `rst` during a write of 99 to addr 7 (previously 0) before the access edge → `ram_wrEn` drops immediately; no `core_ready`; a later read of addr 7 returns 0; state `IDLE`, `rr_ptr` = 0.
- Random soak: 200 cycles of random requests, addresses and data, checked against a reference memory model → every read matches the model; no request waits more than 3·`CORE_COUNT` cycles.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter that serialises core requests onto a
// single-port shared RAM, one access per grant, with a one-cycle ready pulse.
module shared_mem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CORE_COUNT-1:0]                 core_req,
  input  logic [CORE_COUNT-1:0]                 core_wrEn,
  input  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [CORE_COUNT-1:0][WIDTH-1:0]      core_dataIn,
  output logic [CORE_COUNT-1:0]                 core_ready,
  output logic [WIDTH-1:0]                      core_dataOut,
  output logic                                  ram_wrEn,
  output logic [ADDR_WIDTH-1:0]                 ram_addr,
  output logic [WIDTH-1:0]                      ram_dataIn,
  input  logic [WIDTH-1:0]                      ram_dataOut
);

  localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [PTR_W:0]   COUNT_EXT = (PTR_W + 1)'(CORE_COUNT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(CORE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        data_q, data_d;

  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W:0]          cand;

  // Round-robin search: first requesting core at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (cand >= COUNT_EXT) begin
        cand = cand - COUNT_EXT;
      end
      if (!grant_found && core_req[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // State register plus latched grant; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic: grant in IDLE, one RAM cycle, then respond and advance the pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = ACCESS;
          win_d   = grant_idx;
          wr_d    = core_wrEn[grant_idx];
          addr_d  = core_addr[grant_idx];
          data_d  = core_dataIn[grant_idx];
        end
      end
      ACCESS: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        state_d  = IDLE;
        rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: RAM strobe only in ACCESS, ready pulse and read data only in RESPOND.
  always_comb begin
    core_ready   = '0;
    core_dataOut = '0;
    ram_wrEn     = 1'b0;
    ram_addr     = addr_q;
    ram_dataIn   = data_q;
    case (state_q)
      ACCESS: begin
        ram_wrEn = wr_q;
      end
      RESPOND: begin
        core_ready[win_q] = 1'b1;
        core_dataOut      = ram_dataOut;
      end
      default: begin
      end
    endcase
  end

endmodule
